// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - freeze/flush sequencer for the 5-stage pipeline (RAW, branch, memory wait).
// Optional macro HAZARD_FORWARD_EN: forwarding present, only load-use stalls from EXE remain.
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_freeze,
  output logic [4:0]        stage_freeze,
  output logic [4:0]        stage_flush,
  output logic              mem_timeout_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  state_t           r_state;
  logic [7:0]       r_wait_cnt;
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_hit1;
  logic w_hit2;
  logic w_hazard;
  logic w_mem_stall;

`ifdef HAZARD_FORWARD_EN
  logic w_unused_mem;
  assign w_unused_mem = ^{mem_dest, mem_wb_en};
  assign w_hit1 = (id_src1 == exe_dest) & exe_wb_en & exe_mem_r_en;
  assign w_hit2 = (id_src2 == exe_dest) & exe_wb_en & exe_mem_r_en;
`else
  logic w_unused_ld;
  assign w_unused_ld = exe_mem_r_en;
  assign w_hit1 = ((id_src1 == exe_dest) & exe_wb_en) | ((id_src1 == mem_dest) & mem_wb_en);
  assign w_hit2 = ((id_src2 == exe_dest) & exe_wb_en) | ((id_src2 == mem_dest) & mem_wb_en);
`endif

  assign w_hazard    = w_hit1 | (id_two_src & w_hit2);
  // An outstanding access stalls identically whether it is the first cycle (RUN) or a later one (WAIT).
  assign w_mem_stall = (r_state != S_ERR) & mem_req & ~mem_ready;

  always_comb begin
    pc_freeze    = 1'b0;
    stage_freeze = 5'b00000;
    stage_flush  = 5'b00000;
    if (rst) begin
      if (r_state == S_ERR) begin
        pc_freeze    = 1'b1;
        stage_freeze = 5'b11111;
      end else if (w_mem_stall) begin
        pc_freeze    = 1'b1;
        stage_freeze = 5'b01111;
        stage_flush  = 5'b10000;
      end else if (branch_taken) begin
        stage_flush  = 5'b00011;
      end else if (w_hazard) begin
        pc_freeze    = 1'b1;
        stage_freeze = 5'b00001;
        stage_flush  = 5'b00010;
      end
    end
  end

  assign mem_timeout_err = rst & r_err;
  assign stall_cycles    = rst ? r_stall_cnt : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= 8'd0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (pc_freeze && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      case (r_state)
        S_RUN: begin
          if (mem_req && !mem_ready) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        S_WAIT: begin
          if (mem_ready || !mem_req) begin
            r_state <= S_RUN;
          end else if (r_wait_cnt == 8'(MEM_TIMEOUT)) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - table, directed and random checks of pipeline_hazard_ctrl against a rule model.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 4;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic          id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic          branch_taken, mem_req, mem_ready;
  logic          pc_freeze, mem_timeout_err;
  logic [4:0]    stage_freeze, stage_flush;
  logic [CW-1:0] stall_cycles;

  pipeline_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze), .stage_freeze(stage_freeze), .stage_flush(stage_flush),
    .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: sticky error flag, run length of consecutive stalled memory cycles, stall count.
  bit m_err    = 1'b0;
  int m_consec = 0;
  int m_cnt    = 0;

  typedef struct {
    logic [3:0] s1, s2;
    logic       two;
    logic [3:0] ed;
    logic       ewb, eld;
    logic [3:0] md;
    logic       mwb, br, req, rdy;
    logic       epc;
    logic [4:0] efz, efl;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [3:0] s);
    if (FWD) return (s == exe_dest) && exe_wb_en && exe_mem_r_en;
    return ((s == exe_dest) && exe_wb_en) || ((s == mem_dest) && mem_wb_en);
  endfunction

  task automatic expect_now(output logic e_pc, output logic [4:0] e_fz, output logic [4:0] e_fl);
    e_pc = 1'b0; e_fz = 5'd0; e_fl = 5'd0;
    if (rst) begin
      if (m_err) begin
        e_pc = 1'b1; e_fz = 5'b11111;
      end else if (mem_req && !mem_ready) begin
        e_pc = 1'b1; e_fz = 5'b01111; e_fl = 5'b10000;
      end else if (branch_taken) begin
        e_fl = 5'b00011;
      end else if (hit(id_src1) || (id_two_src && hit(id_src2))) begin
        e_pc = 1'b1; e_fz = 5'b00001; e_fl = 5'b00010;
      end
    end
  endtask

  // Inputs are driven at the falling edge; check outputs, then advance the model across the rising edge.
  task automatic cyc();
    logic e_pc;
    logic [4:0] e_fz, e_fl;
    #1;
    expect_now(e_pc, e_fz, e_fl);
    chk("pc_freeze", 32'(pc_freeze), 32'(e_pc));
    chk("stage_freeze", 32'(stage_freeze), 32'(e_fz));
    chk("stage_flush", 32'(stage_flush), 32'(e_fl));
    chk("mem_timeout_err", 32'(mem_timeout_err), 32'(rst && m_err));
    chk("stall_cycles", 32'(stall_cycles), rst ? 32'(m_cnt) : 32'd0);
    @(posedge clk);
    if (!rst) begin
      m_err = 1'b0; m_consec = 0; m_cnt = 0;
    end else begin
      if (e_pc && m_cnt < CNT_MAX) m_cnt++;
      if (!m_err) begin
        m_consec = (mem_req && !mem_ready) ? m_consec + 1 : 0;
        if (m_consec == TO + 1) m_err = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b1; id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
    exe_dest = 4'd14; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd15; mem_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b0; cyc(); rst = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b0; mem_req = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("reset_pc", 32'(pc_freeze), 32'd0);
      chk("reset_flush", 32'(stage_flush), 32'd0);
      cyc();
    end

    // Single-cycle rule table, each applied from RUN with no memory stall.
    vt[0] = '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, !FWD, FWD ? 5'd0 : 5'd1, FWD ? 5'd0 : 5'd2};
    vt[1] = '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2};
    vt[2] = '{4'd5, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, !FWD, FWD ? 5'd0 : 5'd1, FWD ? 5'd0 : 5'd2};
    vt[3] = '{4'd1, 4'd7, 1'b0, 4'd7, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
    vt[4] = '{4'd1, 4'd7, 1'b1, 4'd7, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2};
    vt[5] = '{4'd6, 4'd0, 1'b0, 4'd6, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
    vt[6] = '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3};
    vt[7] = '{4'd0, 4'd0, 1'b0, 4'd9, 1'b0, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3};
    vt[8] = '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2};
    vt[9] = '{4'd2, 4'd0, 1'b0, 4'd9, 1'b0, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      id_src1 = vt[i].s1; id_src2 = vt[i].s2; id_two_src = vt[i].two;
      exe_dest = vt[i].ed; exe_wb_en = vt[i].ewb; exe_mem_r_en = vt[i].eld;
      mem_dest = vt[i].md; mem_wb_en = vt[i].mwb;
      branch_taken = vt[i].br; mem_req = vt[i].req; mem_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d_pc", i), 32'(pc_freeze), 32'(vt[i].epc));
      chk($sformatf("vec%0d_freeze", i), 32'(stage_freeze), 32'(vt[i].efz));
      chk($sformatf("vec%0d_flush", i), 32'(stage_flush), 32'(vt[i].efl));
      cyc();
    end

    // One RAW cycle after reset bumps the counter to exactly 1 (0 with forwarding).
    do_reset();
    id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    cyc();
    idle();
    #1 chk("raw_stall_count", 32'(stall_cycles), FWD ? 32'd0 : 32'd1);
    cyc();

    // Three-cycle memory wait then release.
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("wait_freeze", 32'(stage_freeze), 32'h0f);
      cyc();
    end
    mem_ready = 1'b1;
    #1 chk("release_freeze", 32'(stage_freeze), 32'd0);
    chk("release_pc", 32'(pc_freeze), 32'd0);
    cyc();
    mem_ready = 1'b0;
    #1 chk("new_access_stalls", 32'(stage_flush), 32'h10);
    cyc();
    idle(); cyc();

    // Timeout: MEM_TIMEOUT+1 stalled cycles, then terminal ERR until reset.
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i <= TO; i++) begin
      #1 chk("pre_err_freeze", 32'(stage_freeze), 32'h0f);
      chk("pre_err_flag", 32'(mem_timeout_err), 32'd0);
      cyc();
    end
    mem_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1 chk("err_freeze", 32'(stage_freeze), 32'h1f);
      chk("err_flag", 32'(mem_timeout_err), 32'd1);
      cyc();
    end
    #1 chk("stall_saturate", 32'(stall_cycles), 32'(CNT_MAX));
    do_reset();
    #1 chk("err_cleared", 32'(mem_timeout_err), 32'd0);
    cyc();

    // Branch during a memory stall is held off until the release cycle.
    do_reset();
    mem_req = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("stall_branch_flush", 32'(stage_flush), 32'h10);
      cyc();
    end
    mem_ready = 1'b1;
    #1 chk("release_branch_flush", 32'(stage_flush), 32'h03);
    chk("release_branch_pc", 32'(pc_freeze), 32'd0);
    cyc();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 40) != 0);
      id_src1 = 4'($urandom_range(0, 3)); id_src2 = 4'($urandom_range(0, 3));
      id_two_src = 1'($urandom); exe_dest = 4'($urandom_range(0, 3));
      exe_wb_en = 1'($urandom); exe_mem_r_en = 1'($urandom);
      mem_dest = 4'($urandom_range(0, 3)); mem_wb_en = 1'($urandom);
      branch_taken = ($urandom_range(0, 3) == 0);
      mem_req = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      if (i % 500 == 100) begin
        rst = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
